prach_tv_player: RTL

- Synthesizable TDM AVST stimulus source for PRACH front-end bring-up and in-system self-test.
- Replays a loaded test vector, impulse, ramp or zeros onto the multi-antenna, multi-channel JESD-side AVST stream that feeds the DDC input.
- Emits an aligned sync pulse.
- Generalises fixed 8-antenna / 4-channel playback to parametrised lanes, channels and depth, with flush, looping, lane masking and backpressure.

---
 rtl/prach_tv_pkg.sv | 9 +
 rtl/prach_tv_ram.sv | 20 ++
 rtl/prach_tv_player.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/prach_tv_pkg.sv
// prach_tv_pkg: shared enums and lane slicing for the PRACH test-vector player
package prach_tv_pkg;
  typedef enum logic [1:0] {MODE_ZERO, MODE_IMPULSE, MODE_PLAY, MODE_RAMP} mode_e;
  typedef enum logic [1:0] {IDLE, FLUSH, PLAY} state_e;
  // Antenna 0 sits in the most significant slice of the beat
  function automatic int lane_lo(input int a, input int n, input int w);
    return (n - 1 - a) * w;
  endfunction
endpackage

// File: rtl/prach_tv_ram.sv
// prach_tv_ram: simple dual-port test-vector RAM with one-cycle registered read
module prach_tv_ram #(
  parameter int DEPTH = 32768,
  parameter int W = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk_jesd,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];
  // Write port and registered read port
  always_ff @(posedge clk_jesd) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/prach_tv_player.sv
// prach_tv_player: TDM AVST stimulus source replaying test vectors, impulse, ramp or zeros
module prach_tv_player
  import prach_tv_pkg::*;
#(
  parameter int NUM_ANT = 8,
  parameter int NUM_CHN = 4,
  parameter int SAMPLE_W = 32,
  parameter int TV_DEPTH = 32768,
  parameter int ADDR_W = $clog2(TV_DEPTH)
) (
  input  logic                        clk_jesd,
  input  logic                        rst_jesd,
  input  logic                        tv_wr_en,
  input  logic [ADDR_W-1:0]           tv_wr_addr,
  input  logic [SAMPLE_W-1:0]         tv_wr_data,
  input  logic [1:0]                  cfg_mode,
  input  logic [NUM_ANT-1:0]          cfg_ant_mask,
  input  logic [NUM_CHN-1:0]          cfg_chn_mask,
  input  logic [15:0]                 cfg_flush_len,
  input  logic [ADDR_W:0]             cfg_length,
  input  logic                        cfg_loop,
  input  logic [15:0]                 cfg_sync_offset,
  input  logic [15:0]                 cfg_impulse_amp,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        sync_out,
  output logic [NUM_ANT*SAMPLE_W-1:0] avst_source_data,
  output logic                        avst_source_valid,
  output logic [7:0]                  avst_source_channel,
  input  logic                        avst_source_ready
);
  localparam int CW = NUM_CHN > 1 ? $clog2(NUM_CHN) : 1;
  localparam int IW = ADDR_W + 1 > 16 ? ADDR_W + 1 : 16;
  state_e state, state_n;
  logic [CW-1:0] chn, chn_n, och;
  logic [IW-1:0] idx, idx_n, last_idx;
  mode_e mode_q;
  logic [NUM_ANT-1:0] ant_q;
  logic [NUM_CHN-1:0] chm_q;
  logic [15:0] flush_q, off_q, amp_q, scnt;
  logic [ADDR_W:0] len_q;
  logic loop_q, v, done_q, s_run, go, ld, wrap, last, first, drain;
  logic [SAMPLE_W-1:0] word, q;
  logic [NUM_ANT*SAMPLE_W-1:0] beat, odata;
  // chn/idx/state describe the pending beat; the output register holds the presented one
  assign busy = state != IDLE || v;
  assign go = start && !abort && !busy;
  assign ld = state != IDLE && (!v || avst_source_ready);
  assign wrap = chn == CW'(NUM_CHN - 1);
  assign last_idx = state == FLUSH ? IW'(flush_q) - IW'(1) : IW'(len_q) - IW'(1);
  assign last = wrap && idx == last_idx;
  assign first = ld && state == PLAY && idx == '0 && chn == '0;
  assign drain = v && avst_source_ready && state == IDLE;
  assign word = state != PLAY ? '0 :
                mode_q == MODE_PLAY ? q :
                mode_q == MODE_IMPULSE ? (idx == '0 ? SAMPLE_W'({16'd0, amp_q}) : '0) :
                mode_q == MODE_RAMP ? SAMPLE_W'({idx[15:0], ~idx[15:0]}) : '0;
  for (genvar a = 0; a < NUM_ANT; a++) begin : g_lane
    assign beat[lane_lo(a, NUM_ANT, SAMPLE_W) +: SAMPLE_W] = ant_q[a] && chm_q[chn] ? word : '0;
  end
  // The read address follows the next pending position so RAM data lines up with the load
  prach_tv_ram #(.DEPTH(TV_DEPTH), .W(SAMPLE_W), .AW(ADDR_W)) u_ram (
    .clk_jesd(clk_jesd),
    .wr_en(tv_wr_en && !busy),
    .wr_addr(tv_wr_addr),
    .wr_data(tv_wr_data),
    .rd_addr(idx_n[ADDR_W-1:0]),
    .rd_data(q)
  );
  // Next pending-beat position and phase
  always_comb begin
    state_n = state;
    chn_n = chn;
    idx_n = idx;
    if (abort) begin
      state_n = IDLE;
      chn_n = '0;
      idx_n = '0;
    end else if (state == IDLE) begin
      if (go) state_n = cfg_flush_len != '0 ? FLUSH : cfg_length != '0 ? PLAY : IDLE;
    end else if (ld) begin
      chn_n = wrap ? '0 : chn + 1'b1;
      idx_n = !wrap ? idx : last ? '0 : idx + 1'b1;
      if (last) state_n = (state == FLUSH && len_q != '0) || (state == PLAY && loop_q) ? PLAY : IDLE;
    end
  end
  // Phase register, counters and configuration captured on an accepted start
  always_ff @(posedge clk_jesd) begin
    if (rst_jesd) begin
      state <= IDLE;
      chn <= '0;
      idx <= '0;
      mode_q <= MODE_ZERO;
      ant_q <= '0;
      chm_q <= '0;
      flush_q <= '0;
      len_q <= '0;
      loop_q <= 1'b0;
      off_q <= '0;
      amp_q <= '0;
    end else begin
      state <= state_n;
      chn <= chn_n;
      idx <= idx_n;
      if (go) begin
        mode_q <= mode_e'(cfg_mode);
        ant_q <= cfg_ant_mask;
        chm_q <= cfg_chn_mask;
        flush_q <= cfg_flush_len;
        len_q <= cfg_length;
        loop_q <= cfg_loop;
        off_q <= cfg_sync_offset;
        amp_q <= cfg_impulse_amp;
      end
    end
  end
  // Presented beat, completion pulse and per-pass sync offset counter
  always_ff @(posedge clk_jesd) begin
    if (rst_jesd || abort) begin
      v <= 1'b0;
      odata <= '0;
      och <= '0;
      done_q <= 1'b0;
      s_run <= 1'b0;
      scnt <= '0;
    end else begin
      v <= ld || (v && !avst_source_ready);
      odata <= ld ? beat : avst_source_ready ? '0 : odata;
      och <= ld ? chn : avst_source_ready ? '0 : och;
      done_q <= (go && cfg_flush_len == '0 && cfg_length == '0) || drain;
      s_run <= first || (s_run && scnt != off_q && !drain);
      scnt <= first ? '0 : scnt + 16'd1;
    end
  end
  assign sync_out = s_run && scnt == off_q;
  assign done = done_q;
  assign avst_source_valid = v;
  assign avst_source_data = odata;
  assign avst_source_channel = 8'(och);
endmodule
